// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle for sobel_window_gen.
// The design uses the slave modport and the producer/consumer side uses master.
interface sobel_window_gen_if #(
  parameter int PIX_W = 8,
  parameter int CW    = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PIX_W-1:0]     in_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic [9*PIX_W-1:0]   out_win;
  logic [CW-1:0]        out_row;
  logic [CW-1:0]        out_col;
  logic                 out_eof;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_win, out_row, out_col, out_eof
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_win, out_row, out_col, out_eof
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register.
// Optional SOBEL_WIN_PRESCALE_EN: pixels are shifted right by 2 on entry.
//
// state     | meaning
// ST_FILL   | rows 0..1 of a frame loading the line buffers, no windows
// ST_STREAM | rows 2..IMG_H-1, a window per interior pixel beat
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8,
  parameter int CW    = 7
) (
  input  logic                clk,
  input  logic                reset,
  sobel_window_gen_if.slave   bus
);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic {ST_FILL, ST_STREAM} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      in_col_q, in_col_d;
  logic [CW-1:0]      in_row_q, in_row_d;
  logic               out_valid_q, out_valid_d;
  logic [9*PIX_W-1:0] out_win_q, out_win_d;
  logic [CW-1:0]      out_row_q, out_row_d;
  logic [CW-1:0]      out_col_q, out_col_d;
  logic               out_eof_q, out_eof_d;

  // Storage below is deliberately unreset; FILL keeps stale data out of windows.
  logic [PIX_W-1:0]   lb0_q [IMG_W];
  logic [PIX_W-1:0]   lb1_q [IMG_W];
  logic [PIX_W-1:0]   win_q [9];
  logic [PIX_W-1:0]   win_d [9];

  logic [PIX_W-1:0]   pix_in;
  logic [AW-1:0]      col_idx;
  logic               in_beat;
  logic               last_col;
  logic               last_row;
  logic               emit;

`ifdef SOBEL_WIN_PRESCALE_EN
  assign pix_in = bus.in_pixel >> 2;
`else
  assign pix_in = bus.in_pixel;
`endif

  assign col_idx  = AW'(in_col_q);
  assign last_col = (in_col_q == CW'(IMG_W - 1));
  assign last_row = (in_row_q == CW'(IMG_H - 1));

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign in_beat      = bus.in_valid && bus.in_ready;
  assign emit         = in_beat && (state_q == ST_STREAM) &&
                        (in_row_q >= CW'(2)) && (in_col_q >= CW'(2));

  always_comb begin
    for (int k = 0; k < 9; k++) win_d[k] = win_q[k];
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]   = win_q[3*r+1];
      win_d[3*r+1] = win_q[3*r+2];
    end
    win_d[2] = lb0_q[col_idx];
    win_d[5] = lb1_q[col_idx];
    win_d[8] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (in_beat) begin
      win_q          <= win_d;
      lb0_q[col_idx] <= lb1_q[col_idx];
      lb1_q[col_idx] <= pix_in;
    end
  end

  always_comb begin
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (in_beat) begin
      if (last_col) begin
        in_col_d = '0;
        in_row_d = last_row ? '0 : in_row_q + CW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (in_beat && last_col && (in_row_q == CW'(1))) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (in_beat && last_col && last_row) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // A stalled output blocks in_beat, so "not loading" plus out_ready means drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_win_d   = out_win_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_eof_d   = out_eof_q;
    if (emit) begin
      out_valid_d = 1'b1;
      for (int k = 0; k < 9; k++) out_win_d[k*PIX_W +: PIX_W] = win_d[k];
      out_row_d = in_row_q - CW'(1);
      out_col_d = in_col_q - CW'(1);
      out_eof_d = last_row && last_col;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      in_col_q    <= '0;
      in_row_q    <= '0;
      out_valid_q <= 1'b0;
      out_win_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      out_valid_q <= out_valid_d;
      out_win_q   <= out_win_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_win   = out_win_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_eof   = out_eof_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed-sequence bench for sobel_window_gen with an image-array reference model.
module tb_sobel_window_gen;
  localparam int W    = 64;
  localparam int H    = 64;
  localparam int PW   = 8;
  localparam int CW   = 7;
  localparam int NWIN = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.PIX_W(PW), .CW(CW)) bus ();

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [9*PW-1:0] win;
    logic [CW-1:0]   row;
    logic [CW-1:0]   col;
    logic            eof;
  } exp_t;

  exp_t expq[$];
  int   img [H][W];
  int   rnd [H][W];
  int   mr, mc;
  int   n_cmp, n_bad;
  int   win_seen, eof_seen;
  exp_t first_got, second_got, fw;
  int   ramp_taps [9] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};

  function automatic int src(input int mode, input int r, input int c);
    case (mode)
      0:       return (r * W + c) % 256;
      1:       return 255;
      default: return rnd[r][c];
    endcase
  endfunction

  function automatic int stored(input int p);
`ifdef SOBEL_WIN_PRESCALE_EN
    return p >> 2;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: keep the whole frame, cut the 3x3 neighbourhood straight from it.
  task automatic model_accept(input int p);
    exp_t e;
    img[mr][mc] = stored(p);
    if (mr >= 2 && mc >= 2) begin
      for (int k = 0; k < 9; k++)
        e.win[k*PW +: PW] = PW'(img[mr - 2 + k / 3][mc - 2 + k % 3]);
      e.row = CW'(mr - 1);
      e.col = CW'(mc - 1);
      e.eof = (mr == H - 1) && (mc == W - 1);
      expq.push_back(e);
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic run_frame(input int npix, input int mode, input int vpct, input int rpct,
                           input bit stall, input bit drain, input int limit);
    int   sent = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    bit   stalled = 0;
    exp_t got, e;
    win_seen = 0;
    eof_seen = 0;
    while ((sent < npix || (drain && (expq.size() > 0 || bus.out_valid))) && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (stall && !stalled && bus.out_valid && bus.out_row == CW'(10) && bus.out_col == CW'(20)) begin
        stalled   = 1;
        stall_cnt = 5;
      end
      bus.in_valid  = (sent < npix) && (stall_cnt > 0 || $urandom_range(99) < vpct);
      bus.in_pixel  = PW'(src(mode, mr, mc));
      bus.out_ready = (stall_cnt > 0) ? 1'b0 : ($urandom_range(99) < rpct);
      #1;
      got = {bus.out_win, bus.out_row, bus.out_col, bus.out_eof};
      if (stall_cnt > 0) begin
        chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
        if (expq.size() > 0) chk("stall_hold", 128'(got), 128'(expq[0]));
        stall_cnt--;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_window", 128'(got), 128'(0));
        end else begin
          e = expq.pop_front();
          chk("window", 128'(got), 128'(e));
          win_seen++;
          if (bus.out_eof) eof_seen++;
          if (win_seen == 1) first_got = got;
          if (win_seen == NWIN + 1) second_got = got;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        model_accept(int'(bus.in_pixel));
        sent++;
      end
    end
    chk("timeout", 128'(cyc < limit), 128'(1));
    if (stall) chk("stall_seen", 128'(stalled), 128'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "_out_win"},   128'(bus.out_win),   128'(0));
    chk({tag, "_out_rc"},    128'({bus.out_row, bus.out_col}), 128'(0));
    chk({tag, "_out_eof"},   128'(bus.out_eof),   128'(0));
    chk({tag, "_in_ready"},  128'(bus.in_ready),  128'(1));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mr = 0;
    mc = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) rnd[r][c] = int'($urandom_range(255));

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    reset = 1'b1;

    // Ramp frame, continuous handshake.
    run_frame(W * H, 0, 100, 100, 0, 1, 10000);
    chk("ramp_count", 128'(win_seen), 128'(NWIN));
    chk("ramp_eof_count", 128'(eof_seen), 128'(1));
    for (int k = 0; k < 9; k++) fw.win[k*PW +: PW] = PW'(stored(ramp_taps[k]));
    fw.row = CW'(1);
    fw.col = CW'(1);
    fw.eof = 1'b0;
    chk("ramp_first", 128'(first_got), 128'(fw));

    // Ramp frame with a 5-cycle stall on window (10,20).
    run_frame(W * H, 0, 100, 100, 1, 1, 10000);
    chk("stall_count", 128'(win_seen), 128'(NWIN));
    chk("stall_eof_count", 128'(eof_seen), 128'(1));

    // Random pixels, random valid gaps and backpressure.
    run_frame(W * H, 2, 50, 50, 0, 1, 25000);
    chk("rand_count", 128'(win_seen), 128'(NWIN));
    chk("rand_eof_count", 128'(eof_seen), 128'(1));

    // 1000 beats, reset mid-frame, then a fresh frame.
    run_frame(1000, 0, 100, 100, 0, 0, 3000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    expq.delete();
    mr = 0;
    mc = 0;
    @(negedge clk);
    reset = 1'b1;
    run_frame(W * H, 0, 100, 100, 0, 1, 10000);
    chk("post_rst_count", 128'(win_seen), 128'(NWIN));
    chk("post_rst_first", 128'(first_got), 128'(fw));

    // Two frames back to back.
    run_frame(2 * W * H, 0, 100, 100, 0, 1, 20000);
    chk("b2b_count", 128'(win_seen), 128'(2 * NWIN));
    chk("b2b_eof_count", 128'(eof_seen), 128'(2));
    chk("b2b_second_first", 128'(second_got), 128'(fw));

    // Constant full-scale frame.
    run_frame(W * H, 1, 100, 100, 0, 1, 10000);
    chk("const_count", 128'(win_seen), 128'(NWIN));
    for (int k = 0; k < 9; k++) fw.win[k*PW +: PW] = PW'(stored(255));
    chk("const_first", 128'(first_got), 128'(fw));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
